// File: rtl/mem_access_unit.sv
// mem_access_unit: turns multicycle-controller memory strobes into a valid/ready bus
// transaction, holds IR and MDR, and stalls the controller until the access completes.
// Optional build macro MAU_TIMEOUT_EN: abort an access after TIMEOUT_CYCLES without bus_ready.
module mem_access_unit #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iord,
  input  logic              ir_write,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] instr,
  output logic [5:0]        opcode,
  output logic [5:0]        funct,
  output logic [DATA_W-1:0] mdr,
  output logic              stall,
  output logic              err,
  output logic              bus_valid,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ready,
  input  logic [DATA_W-1:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state, next_state;
  logic              is_fetch;
  logic              is_read;
  logic              req;
  logic              multi_req;
  logic [ADDR_W-1:0] sel_addr;
  logic              complete;
  logic              abort;

  assign req       = mem_write | ir_write | mem_read;
  assign multi_req = (mem_write & ir_write) | (mem_write & mem_read) | (ir_write & mem_read);
  assign sel_addr  = iord ? alu_out : pc;
  assign complete  = (state == ACCESS) && bus_ready;
  assign opcode    = instr[31:26];
  assign funct     = instr[5:0];

`ifdef MAU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  // Count ACCESS cycles; cleared while idle so every access starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state == ACCESS) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  // Limit reached in this ACCESS cycle; a simultaneous bus_ready still completes normally.
  assign abort = (state == ACCESS) && !bus_ready &&
                 (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign abort = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state, stall and bus_valid; bus_valid follows the state so reset drops it at once.
  always_comb begin
    next_state = state;
    stall      = 1'b0;
    bus_valid  = 1'b0;
    case (state)
      IDLE: begin
        stall = req;
        if (req) next_state = ACCESS;
      end
      ACCESS: begin
        stall     = 1'b1;
        bus_valid = 1'b1;
        if (complete || abort) next_state = DONE;
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Capture the winning request into the bus registers and load IR/MDR on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_fetch  <= 1'b0;
      is_read   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      instr     <= '0;
      mdr       <= '0;
      err       <= 1'b0;
    end else begin
      if (state == IDLE && req) begin
        bus_we    <= mem_write;
        is_fetch  <= !mem_write && ir_write;
        is_read   <= !mem_write && !ir_write && mem_read;
        bus_addr  <= {sel_addr[ADDR_W-1:2], 2'b00};
        bus_wdata <= wdata;
        if (multi_req || (sel_addr[1:0] != 2'b00)) err <= 1'b1;
      end
      if (complete) begin
        if (is_fetch) instr <= bus_rdata;
        if (is_read)  mdr   <= bus_rdata;
      end else if (abort) begin
        err <= 1'b1;
        if (is_fetch) instr <= '0;
        if (is_read)  mdr   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios followed by randomized transactions
// checked against an architectural model of IR, MDR, err and bus timing.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iord, ir_write, mem_read, mem_write;
  logic [31:0] pc, alu_out, wdata;
  logic [31:0] instr, mdr, bus_addr, bus_wdata, bus_rdata;
  logic [5:0]  opcode, funct;
  logic        stall, err, bus_valid, bus_we, bus_ready;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_instr, exp_mdr;
  logic        exp_err;

  mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .iord(iord), .ir_write(ir_write), .mem_read(mem_read),
    .mem_write(mem_write), .pc(pc), .alu_out(alu_out), .wdata(wdata), .instr(instr),
    .opcode(opcode), .funct(funct), .mdr(mdr), .stall(stall), .err(err),
    .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_instr"}, instr, exp_instr);
    check({tag, "_opcode"}, {26'd0, opcode}, {26'd0, exp_instr[31:26]});
    check({tag, "_funct"}, {26'd0, funct}, {26'd0, exp_instr[5:0]});
    check({tag, "_mdr"}, mdr, exp_mdr);
    check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
  endtask

  task automatic idle_inputs();
    mem_write = 0; ir_write = 0; mem_read = 0; iord = 0; bus_ready = 0;
  endtask

  task automatic apply_reset();
    rst_n = 0;
    idle_inputs();
    #1;
    exp_instr = 0; exp_mdr = 0; exp_err = 0;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  // One full transaction, starting in IDLE at 1 time unit past a rising edge.
  task automatic do_txn(input logic w, input logic f, input logic r, input logic io,
                        input logic [31:0] pcv, input logic [31:0] alv,
                        input logic [31:0] wd, input logic [31:0] rd,
                        input int waits, input string tag);
    logic [31:0] sel;
    logic        is_w, is_f, is_r;
    int          hi;
    sel  = io ? alv : pcv;
    is_w = w;
    is_f = !w && f;
    is_r = !w && !f && r;
    mem_write = w; ir_write = f; mem_read = r; iord = io;
    pc = pcv; alu_out = alv; wdata = wd; bus_ready = 0; bus_rdata = $urandom;
    hi = 0;
    #1;
    if (stall) hi++;
    check({tag, "_idle_valid"}, {31'd0, bus_valid}, 32'd0);
    @(posedge clk); #1;
    for (int k = 0; k <= waits; k++) begin
      check({tag, "_valid"}, {31'd0, bus_valid}, 32'd1);
      check({tag, "_addr"}, bus_addr, {sel[31:2], 2'b00});
      check({tag, "_we"}, {31'd0, bus_we}, {31'd0, is_w});
      if (is_w) check({tag, "_wdata"}, bus_wdata, wd);
      if (stall) hi++;
      bus_ready = (k == waits);
      bus_rdata = (k == waits) ? rd : $urandom;
      @(posedge clk); #1;
    end
    bus_ready = 0;
    bus_rdata = $urandom;
    // DONE: strobes still asserted, yet stall must be low.
    check({tag, "_done_stall"}, {31'd0, stall}, 32'd0);
    check({tag, "_done_valid"}, {31'd0, bus_valid}, 32'd0);
    check({tag, "_stall_cycles"}, hi, waits + 2);
    if ((int'(w) + int'(f) + int'(r) > 1) || sel[1:0] != 2'b00) exp_err = 1;
    if (is_f) exp_instr = rd;
    if (is_r) exp_mdr = rd;
    @(posedge clk); #1;
    idle_inputs();
    #1;
    check({tag, "_idle_stall"}, {31'd0, stall}, 32'd0);
    check_regs(tag);
  endtask

  initial begin
    idle_inputs();
    pc = 0; alu_out = 0; wdata = 0; bus_rdata = 0;
    rst_n = 0;
    #2;
    check("rst_instr", instr, 32'd0);
    check("rst_mdr", mdr, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_valid", {31'd0, bus_valid}, 32'd0);
    check("rst_we", {31'd0, bus_we}, 32'd0);
    check("rst_addr", bus_addr, 32'd0);
    check("rst_wdata", bus_wdata, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    apply_reset();

    // Fetch, ready in the first ACCESS cycle.
    do_txn(0, 1, 0, 0, 32'h0040_0004, 32'h0, 32'h0, 32'h2008_000A, 0, "fetch");
    check("fetch_opcode_lit", {26'd0, opcode}, 32'h08);
    check("fetch_funct_lit", {26'd0, funct}, 32'h0A);
    // Load with three wait cycles.
    do_txn(0, 0, 1, 1, 32'h0040_0008, 32'h1001_0000, 32'h0, 32'hDEAD_BEEF, 3, "load");
    // Store.
    do_txn(1, 0, 0, 1, 32'h0040_000C, 32'h1001_0008, 32'h1234_5678, 32'hFFFF_FFFF, 2, "store");
    check("store_err_lit", {31'd0, err}, 32'd0);
    // Simultaneous write and read: write wins, err set.
    do_txn(1, 0, 1, 1, 32'h0, 32'h1001_0010, 32'hCAFE_0001, 32'h5555_AAAA, 1, "conflict");
    check("conflict_err_lit", {31'd0, err}, 32'd1);

    // Misaligned address after reset.
    apply_reset();
    do_txn(0, 0, 1, 1, 32'h0, 32'h1001_0002, 32'h0, 32'h0BAD_F00D, 0, "misalign");

    // Reset during a wait state.
    do_txn(0, 1, 0, 0, 32'h0040_0010, 32'h0, 32'h0, 32'h0123_4567, 0, "pre_rst");
    mem_read = 1; iord = 1; alu_out = 32'h1001_0020; bus_ready = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midrst_valid_before", {31'd0, bus_valid}, 32'd1);
    rst_n = 0;
    #1;
    check("midrst_valid", {31'd0, bus_valid}, 32'd0);
    check("midrst_instr", instr, 32'd0);
    check("midrst_mdr", mdr, 32'd0);
    check("midrst_err", {31'd0, err}, 32'd0);
    idle_inputs();
    #1;
    check("midrst_stall", {31'd0, stall}, 32'd0);
    apply_reset();

`ifdef MAU_TIMEOUT_EN
    begin
      int n;
      ir_write = 1; iord = 0; pc = 32'h0040_0020; bus_ready = 0;
      do_txn(0, 1, 0, 0, 32'h0040_0024, 32'h0, 32'h0, 32'h1111_2222, 0, "pre_to");
      ir_write = 1; pc = 32'h0040_0028;
      @(posedge clk); #1;
      n = 0;
      while (bus_valid && n < 40) begin
        n++;
        @(posedge clk); #1;
      end
      check("to_cycles", n, 32'd16);
      check("to_stall", {31'd0, stall}, 32'd0);
      check("to_instr", instr, 32'd0);
      check("to_err", {31'd0, err}, 32'd1);
      @(posedge clk); #1;
      idle_inputs();
      apply_reset();
    end
`endif

    // Randomized transactions against the model.
    for (int i = 0; i < 40; i++) begin
      logic w, f, r;
      logic [31:0] a;
      int t;
      t = $urandom_range(0, 2);
      w = (t == 0); f = (t == 1); r = (t == 2);
      if ($urandom_range(0, 9) == 0) begin
        w = 1'b1; r = 1'b1;
      end
      a = $urandom;
      if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      do_txn(w, f, r, f ? 1'b0 : 1'b1, a, a, $urandom, $urandom,
             $urandom_range(0, 5), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
